// File: rtl/ntlm_crack_scheduler.sv
// ============================================================================
// ntlm_crack_scheduler
//
// Brute-force search controller for a shared NTLM hash core. It walks every
// candidate password made of characters CHAR_LO..CHAR_HI, from min_len up to
// max_len characters. Each candidate goes to the hash core over a start/done
// handshake, and the returned hash is compared with the target. The search
// stops at the first match or when every candidate has been tried.
//
// Optional feature macro: NTLM_SCHED_ABORT_EN
//   When defined, an extra 'abort' input ends a running search on the next
//   edge with found=0. The attempt counter keeps its value at that point.
//
// Ports:
//   clk          in   clock
//   n_rst        in   asynchronous active-low reset
//   start        in   begin search (sampled only in IDLE or DONE)
//   abort        in   cancel a running search (NTLM_SCHED_ABORT_EN only)
//   target_hash  in   128-bit hash to find, latched on accepted start
//   min_len      in   shortest candidate length, latched on accepted start
//   max_len      in   longest candidate length, latched on accepted start
//   core_instr   out  candidate string; char i sits in bits [127-8i -: 8]
//                     (char 0 is the most significant byte); unused bytes = 0
//   core_length  out  candidate length
//   core_start   out  one-cycle request pulse to the core
//   core_done    in   core result valid (single cycle)
//   core_hash    in   core result, valid while core_done=1
//   busy         out  search in progress (LOAD/ISSUE/WAIT/CHECK)
//   done         out  search finished; held until the next accepted start
//   found        out  valid with done; 1 = match
//   match_str    out  matching candidate when found, else zero
//   match_len    out  matching length when found, else zero
//   attempts     out  hash compares in the current or last search (saturating)
// ============================================================================
module ntlm_crack_scheduler #(
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] CHAR_LO = 8'h61,
    parameter logic [7:0] CHAR_HI = 8'h7A
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
`ifdef NTLM_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] target_hash,
    input  logic [3:0]   min_len,
    input  logic [3:0]   max_len,
    output logic [127:0] core_instr,
    output logic [3:0]   core_length,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_hash,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [127:0] match_str,
    output logic [3:0]   match_len,
    output logic [31:0]  attempts
);

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [127:0]  r_target;
    logic [3:0]    r_min_len;
    logic [3:0]    r_max_len;
    logic [127:0]  r_hash;
    logic [127:0]  r_instr;
    logic [3:0]    r_len;
    logic          r_core_start;
    logic          r_busy;
    logic          r_done;
    logic          r_found;
    logic [127:0]  r_match_str;
    logic [3:0]    r_match_len;
    logic [31:0]   r_attempts;

    logic [127:0]  w_init_instr;   // min_len copies of CHAR_LO
    logic [127:0]  w_roll_instr;   // (len+1) copies of CHAR_LO
    logic [127:0]  w_step_instr;   // odometer increment at the current length
    logic          w_carry;        // running carry while stepping the odometer
    logic          w_overflow;     // carry out of char 0
    logic [7:0]    w_cur_char;
    logic [4:0]    w_len_plus1;
    logic          w_exhausted;
    logic          w_cfg_invalid;

    assign w_len_plus1   = {1'b0, r_len} + 5'd1;
    assign w_exhausted   = (w_len_plus1 > {1'b0, r_max_len});
    assign w_cfg_invalid = (r_min_len == 4'd0) ||
                           (r_min_len > r_max_len) ||
                           (r_max_len > MAX_LEN_L);

    // Fresh-length candidates: the first 'n' bytes are CHAR_LO, the rest zero.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_fill
            localparam logic [4:0] POS = 5'(gi);
            assign w_init_instr[127-8*gi -: 8] =
                (POS < {1'b0, r_min_len}) ? CHAR_LO : 8'h00;
            assign w_roll_instr[127-8*gi -: 8] =
                (POS < w_len_plus1) ? CHAR_LO : 8'h00;
        end
    endgenerate

    // Odometer step: walk from the rightmost active char towards char 0,
    // wrapping CHAR_HI to CHAR_LO and propagating the carry. Inactive bytes
    // (index >= length) stay zero. Done as a loop in one block so the carry
    // chain is a plain sequential evaluation rather than a vector feedback.
    always_comb begin
        w_step_instr = '0;
        w_carry      = 1'b1;
        w_cur_char   = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            w_cur_char = r_instr[127-8*i -: 8];
            if (i < int'(r_len)) begin
                if (w_carry) begin
                    if (w_cur_char == CHAR_HI) begin
                        w_step_instr[127-8*i -: 8] = CHAR_LO;
                    end else begin
                        w_step_instr[127-8*i -: 8] = w_cur_char + 8'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    w_step_instr[127-8*i -: 8] = w_cur_char;
                end
            end
        end
        w_overflow = w_carry;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_target     <= '0;
            r_min_len    <= '0;
            r_max_len    <= '0;
            r_hash       <= '0;
            r_instr      <= '0;
            r_len        <= '0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_match_str  <= '0;
            r_match_len  <= '0;
            r_attempts   <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_target    <= target_hash;
                        r_min_len   <= min_len;
                        r_max_len   <= max_len;
                        r_done      <= 1'b0;
                        r_found     <= 1'b0;
                        r_match_str <= '0;
                        r_match_len <= '0;
                        r_attempts  <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_cfg_invalid) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_found <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_instr      <= w_init_instr;
                        r_len        <= r_min_len;
                        r_core_start <= 1'b1;   // high for the ISSUE cycle
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        r_hash  <= core_hash;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_attempts != 32'hFFFF_FFFF) begin
                        r_attempts <= r_attempts + 32'd1;
                    end
                    if (r_hash == r_target) begin
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_found     <= 1'b1;
                        r_match_str <= r_instr;
                        r_match_len <= r_len;
                        r_state     <= S_DONE;
                    end else if (w_overflow && w_exhausted) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_found <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_instr      <= w_overflow ? w_roll_instr : w_step_instr;
                        r_len        <= w_overflow ? w_len_plus1[3:0] : r_len;
                        r_core_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
`ifdef NTLM_SCHED_ABORT_EN
            // Abort overrides whatever the busy state decided this cycle,
            // including the CHECK increment, so attempts stays frozen.
            if (abort && r_busy) begin
                r_busy       <= 1'b0;
                r_done       <= 1'b1;
                r_found      <= 1'b0;
                r_match_str  <= '0;
                r_match_len  <= '0;
                r_attempts   <= r_attempts;
                r_core_start <= 1'b0;
                r_state      <= S_DONE;
            end
`endif
        end
    end

    assign core_instr  = r_instr;
    assign core_length = r_len;
    assign core_start  = r_core_start;
    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign match_str   = r_match_str;
    assign match_len   = r_match_len;
    assign attempts    = r_attempts;

endmodule

// File: tb/tb_ntlm_crack_scheduler.sv
// ============================================================================
// tb_ntlm_crack_scheduler
//
// Directed bench for ntlm_crack_scheduler. A behavioural NTLM core (MD4 over
// the UTF-16LE candidate) answers each core_start with 2 cycles of latency.
// Expected search results are queued when a search is launched and popped
// when the scheduler raises done.
// ============================================================================
module tb_ntlm_crack_scheduler;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [127:0] target_hash;
    logic [3:0]   min_len;
    logic [3:0]   max_len;
    logic [127:0] core_instr;
    logic [3:0]   core_length;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_hash;
    logic         busy;
    logic         done;
    logic         found;
    logic [127:0] match_str;
    logic [3:0]   match_len;
    logic [31:0]  attempts;
`ifdef NTLM_SCHED_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;
    int core_start_cnt = 0;
    int core_done_cnt = 0;

    typedef struct {
        string        tag;
        logic         found;
        logic [127:0] str;
        logic [3:0]   len;
        logic [31:0]  att;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    ntlm_crack_scheduler #(
        .MAX_LEN (8),
        .CHAR_LO (8'h61),
        .CHAR_HI (8'h7A)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
`ifdef NTLM_SCHED_ABORT_EN
        .abort       (abort),
`endif
        .target_hash (target_hash),
        .min_len     (min_len),
        .max_len     (max_len),
        .core_instr  (core_instr),
        .core_length (core_length),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_hash   (core_hash),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .match_str   (match_str),
        .match_len   (match_len),
        .attempts    (attempts)
    );

    // ---------------------------------------------------------------- helpers
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // NTLM = MD4(UTF-16LE(password)); candidates fit in a single block.
    function automatic logic [127:0] ntlm(input logic [127:0] s, input int len);
        logic [7:0]  m  [64];
        logic [31:0] x  [16];
        logic [31:0] st [4];
        logic [31:0] h0 [4];
        int          r3k [16];
        int          s1 [4];
        int          s2 [4];
        int          s3 [4];
        logic [31:0] f, tmp, add, b, c, d, bits;
        int          t, k, sh;
        r3k = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        s1  = '{3, 7, 11, 19};
        s2  = '{3, 5, 9, 13};
        s3  = '{3, 9, 11, 15};
        for (int i = 0; i < 64; i++) m[i] = 8'h00;
        for (int i = 0; i < len; i++) m[2*i] = s[127-8*i -: 8];
        m[2*len] = 8'h80;
        bits  = 32'(len * 16);
        m[56] = bits[7:0];
        m[57] = bits[15:8];
        for (int j = 0; j < 16; j++) x[j] = {m[4*j+3], m[4*j+2], m[4*j+1], m[4*j]};
        st[0] = 32'h67452301; st[1] = 32'hEFCDAB89;
        st[2] = 32'h98BADCFE; st[3] = 32'h10325476;
        for (int j = 0; j < 4; j++) h0[j] = st[j];
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                t = (4 - (i % 4)) % 4;
                b = st[(t + 1) % 4];
                c = st[(t + 2) % 4];
                d = st[(t + 3) % 4];
                case (r)
                    0: begin f = (b & c) | (~b & d); k = i; sh = s1[i % 4]; add = 32'h0; end
                    1: begin f = (b & c) | (b & d) | (c & d); k = (i % 4) * 4 + i / 4;
                             sh = s2[i % 4]; add = 32'h5A827999; end
                    default: begin f = b ^ c ^ d; k = r3k[i]; sh = s3[i % 4]; add = 32'h6ED9EBA1; end
                endcase
                tmp   = st[t] + f + x[k] + add;
                st[t] = (tmp << sh) | (tmp >> (32 - sh));
            end
        end
        for (int j = 0; j < 4; j++) st[j] = st[j] + h0[j];
        return {bswap(st[0]), bswap(st[1]), bswap(st[2]), bswap(st[3])};
    endfunction

    function automatic logic [127:0] mkstr(input string w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < w.len(); i++) r[127-8*i -: 8] = w[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------- behavioural hash core
    initial begin : core_model
        logic [127:0] cap_instr;
        logic [3:0]   cap_len;
        core_done = 1'b0;
        core_hash = '0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            core_hash = '0;
            if (core_start === 1'b1) begin
                core_start_cnt++;
                cap_instr = core_instr;
                cap_len   = core_length;
                @(negedge clk);
                @(negedge clk);
                core_hash = ntlm(cap_instr, int'(cap_len));
                core_done = 1'b1;
                core_done_cnt++;
            end
        end
    end

    // -------------------------------------------------------- search driver
    task automatic run_search(input string tag, input string tword,
                              input logic [3:0] mn, input logic [3:0] mx,
                              input logic exp_found, input logic [31:0] exp_att,
                              input bit poke);
        exp_t e;
        int   n;
        e.tag   = tag;
        e.found = exp_found;
        e.str   = exp_found ? mkstr(tword) : 128'h0;
        e.len   = exp_found ? 4'(tword.len()) : 4'd0;
        e.att   = exp_att;
        sb_q.push_back(e);

        @(negedge clk);
        target_hash = ntlm(mkstr(tword), tword.len());
        min_len     = mn;
        max_len     = mx;
        start       = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_load"}, 128'(busy), 128'(1'b1));
        check({tag, "_done_clr"}, 128'(done), 128'(1'b0));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_core_start"}, 128'(core_start), 128'(1'b1));
        check({tag, "_first_len"}, 128'(core_length), 128'(mn));

        if (poke) begin
            repeat (10) @(negedge clk);
            start       = 1'b1;
            min_len     = 4'd3;
            max_len     = 4'd2;
            target_hash = '0;
            @(negedge clk);
            start = 1'b0;
        end

        n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, 128'(done), 128'(1'b1));

        e = sb_q.pop_front();
        $display("search %s: found=%0d len=%0d attempts=%0d", e.tag, found, match_len, attempts);
        check({e.tag, "_found"}, 128'(found), 128'(e.found));
        check({e.tag, "_match_str"}, match_str, e.str);
        check({e.tag, "_match_len"}, 128'(match_len), 128'(e.len));
        check({e.tag, "_attempts"}, 128'(attempts), 128'(e.att));
        check({e.tag, "_busy_end"}, 128'(busy), 128'(1'b0));
        repeat (3) @(posedge clk); #1;
        check({e.tag, "_done_held"}, 128'(done), 128'(1'b1));
    endtask

    task automatic run_invalid(input string tag, input logic [3:0] mn, input logic [3:0] mx);
        int cs0;
        cs0 = core_start_cnt;
        @(negedge clk);
        target_hash = ntlm(mkstr("a"), 1);
        min_len     = mn;
        max_len     = mx;
        start       = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy_load"}, 128'(busy), 128'(1'b1));
        check({tag, "_done_early"}, 128'(done), 128'(1'b0));
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        $display("invalid %s: done=%0d found=%0d attempts=%0d", tag, done, found, attempts);
        check({tag, "_done"}, 128'(done), 128'(1'b1));
        check({tag, "_found"}, 128'(found), 128'(1'b0));
        check({tag, "_attempts"}, 128'(attempts), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(1'b0));
        repeat (3) @(posedge clk); #1;
        check({tag, "_no_core_start"}, 128'(core_start_cnt), 128'(cs0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_instr"}, core_instr, 128'h0);
        check({tag, "_core_length"}, 128'(core_length), 128'h0);
        check({tag, "_core_start"}, 128'(core_start), 128'h0);
        check({tag, "_busy"}, 128'(busy), 128'h0);
        check({tag, "_done"}, 128'(done), 128'h0);
        check({tag, "_found"}, 128'(found), 128'h0);
        check({tag, "_match_str"}, match_str, 128'h0);
        check({tag, "_match_len"}, 128'(match_len), 128'h0);
        check({tag, "_attempts"}, 128'(attempts), 128'h0);
    endtask

    // ------------------------------------------------------------- watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ main flow
    initial begin
        int    idx0, idx1, n, base;
        string rw;

        n_rst       = 1'b0;
        start       = 1'b0;
        target_hash = '0;
        min_len     = '0;
        max_len     = '0;
`ifdef NTLM_SCHED_ABORT_EN
        abort       = 1'b0;
`endif
        #1;
        check_all_zero("reset_async");
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_idle");

        // Directed searches from the test plan.
        run_search("ba_2_2", "ba", 4'd2, 4'd2, 1'b1, 32'd27, 1'b0);
        check("ba_top_bytes", 128'(match_str[127:112]), 128'(16'h6261));
        run_search("zz_1_1", "zz", 4'd1, 4'd1, 1'b0, 32'd26, 1'b0);
        run_search("aa_1_2", "aa", 4'd1, 4'd2, 1'b1, 32'd27, 1'b0);

        // Invalid configurations.
        run_invalid("min_gt_max", 4'd3, 4'd2);
        run_invalid("min_zero", 4'd0, 4'd2);
        run_invalid("max_too_big", 4'd2, 4'd9);

        // Random two-char target searched from length 1; a mid-run start
        // with a bogus config must be ignored.
        idx0 = int'($urandom_range(0, 25));
        idx1 = int'($urandom_range(0, 25));
        rw   = "aa";
        rw.putc(0, 8'(97 + idx0));
        rw.putc(1, 8'(97 + idx1));
        run_search("rand_1_2", rw, 4'd1, 4'd2, 1'b1, 32'(26 + idx0 * 26 + idx1 + 1), 1'b1);

        // Reset in the middle of a search.
        @(negedge clk);
        target_hash = ntlm(mkstr("ba"), 2);
        min_len     = 4'd2;
        max_len     = 4'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (core_start !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_core_start_seen", 128'(core_start), 128'(1'b1));
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        $display("reset mid-run: busy=%0d core_start=%0d attempts=%0d", busy, core_start, attempts);
        check_all_zero("midrst_async");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(posedge clk); #1;
        check_all_zero("midrst_after_core_done");
        run_search("ba_after_rst", "ba", 4'd2, 4'd2, 1'b1, 32'd27, 1'b0);

`ifdef NTLM_SCHED_ABORT_EN
        // Abort after the fifth CHECK.
        @(negedge clk);
        target_hash = ntlm(mkstr("zz"), 2);
        min_len     = 4'd2;
        max_len     = 4'd2;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base = core_done_cnt;
        n = 0;
        while (core_done_cnt < base + 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reached_5", 128'(core_done_cnt - base), 128'(5));
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        $display("abort: done=%0d found=%0d attempts=%0d", done, found, attempts);
        check("abort_done", 128'(done), 128'(1'b1));
        check("abort_busy", 128'(busy), 128'(1'b0));
        check("abort_found", 128'(found), 128'(1'b0));
        check("abort_attempts", 128'(attempts), 128'(5));
        @(negedge clk);
        abort = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("abort_attempts_frozen", 128'(attempts), 128'(5));
        check("abort_done_held", 128'(done), 128'(1'b1));
        check("abort_core_start", 128'(core_start), 128'(1'b0));
`else
        base = 0;
`endif

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
